// File: rtl/sha_nonce_dispatcher_if.sv
// Link between the nonce dispatcher (initiator) and the SHAcomputationalBlock core.
// The signal names match the core's existing port names.
interface sha_nonce_dispatcher_if;
    logic [439:0] inputMsg;
    logic [63:0]  inputLength;
    logic         beginComputation;
    logic         computationComplete;
    logic [255:0] SHAoutput;

    modport master (
        output inputMsg,
        output inputLength,
        output beginComputation,
        input  computationComplete,
        input  SHAoutput
    );

    modport slave (
        input  inputMsg,
        input  inputLength,
        input  beginComputation,
        output computationComplete,
        output SHAoutput
    );
endinterface

// File: rtl/sha_nonce_dispatcher.sv
// Nonce search controller. It walks a nonce range and hands {prefix, nonce} to the
// SHA core, one block per nonce. Each digest is compared against a 256-bit target.
// The search stops on a hit, on range exhaustion, on a core timeout or on a host abort.
module sha_nonce_dispatcher #(
    parameter int PREFIX_W = 408,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [255:0]        target,
    input  logic [31:0]         nonce_start,
    input  logic [31:0]         nonce_end,
    sha_nonce_dispatcher_if.master core,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic                exhausted,
    output logic                timeout_err,
    output logic [31:0]         found_nonce,
    output logic [255:0]        found_hash,
    output logic [31:0]         hash_count
);

    localparam int MSG_W = 440;
    // The counter only has to reach TIMEOUT-1: the last WAIT cycle is index TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [PREFIX_W-1:0] prefix_r, prefix_s;
    logic [255:0]        target_r, target_s;
    logic [31:0]         nonce_r, nonce_s;
    logic [31:0]         nonce_end_r, nonce_end_s;
    logic [255:0]        digest_r, digest_s;
    logic [CNT_W-1:0]    wait_cnt_r, wait_cnt_s;
    logic [MSG_W-1:0]    msg_r, msg_s;
    logic                begin_r, begin_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                found_r, found_s;
    logic                exhausted_r, exhausted_s;
    logic                timeout_r, timeout_s;
    logic [31:0]         found_nonce_r, found_nonce_s;
    logic [255:0]        found_hash_r, found_hash_s;
    logic [31:0]         hash_count_r, hash_count_s;

    // Next-state and next-register values; all outputs are registered from these.
    always_comb begin
        state_s       = state_r;
        prefix_s      = prefix_r;
        target_s      = target_r;
        nonce_s       = nonce_r;
        nonce_end_s   = nonce_end_r;
        digest_s      = digest_r;
        wait_cnt_s    = wait_cnt_r;
        found_s       = found_r;
        exhausted_s   = exhausted_r;
        timeout_s     = timeout_r;
        found_nonce_s = found_nonce_r;
        found_hash_s  = found_hash_r;
        hash_count_s  = hash_count_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    prefix_s      = prefix;
                    target_s      = target;
                    nonce_s       = nonce_start;
                    nonce_end_s   = nonce_end;
                    found_s       = 1'b0;
                    exhausted_s   = 1'b0;
                    timeout_s     = 1'b0;
                    found_nonce_s = 32'd0;
                    found_hash_s  = 256'd0;
                    hash_count_s  = 32'd0;
                    state_s       = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else begin
                    wait_cnt_s = '0;
                    state_s    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Index 0 is the blanking cycle: a complete level left over from the
                // previous hash must not be taken as this hash's result.
                if (abort) begin
                    state_s = ST_DONE;
                end else if ((wait_cnt_r != '0) && core.computationComplete) begin
                    digest_s = core.SHAoutput;
                    state_s  = ST_CHECK;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_s = ST_DONE;
                end else begin
                    if (hash_count_r == 32'hFFFF_FFFF) begin
                        hash_count_s = hash_count_r;
                    end else begin
                        hash_count_s = hash_count_r + 32'd1;
                    end
                    if (digest_r < target_r) begin
                        found_s       = 1'b1;
                        found_nonce_s = nonce_r;
                        found_hash_s  = digest_r;
                        state_s       = ST_DONE;
                    end else if (nonce_r == nonce_end_r) begin
                        exhausted_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        nonce_s = nonce_r + 32'd1;
                        state_s = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        begin_s = (state_s == ST_ISSUE);
        busy_s  = (state_s != ST_IDLE);
        done_s  = (state_s == ST_DONE);
        // The message changes only on entry to ISSUE, so it holds through WAIT and CHECK.
        if (state_s == ST_ISSUE) begin
            msg_s = MSG_W'({prefix_s, nonce_s});
        end else begin
            msg_s = msg_r;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            prefix_r      <= '0;
            target_r      <= 256'd0;
            nonce_r       <= 32'd0;
            nonce_end_r   <= 32'd0;
            digest_r      <= 256'd0;
            wait_cnt_r    <= '0;
            msg_r         <= '0;
            begin_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            found_r       <= 1'b0;
            exhausted_r   <= 1'b0;
            timeout_r     <= 1'b0;
            found_nonce_r <= 32'd0;
            found_hash_r  <= 256'd0;
            hash_count_r  <= 32'd0;
        end else begin
            state_r       <= state_s;
            prefix_r      <= prefix_s;
            target_r      <= target_s;
            nonce_r       <= nonce_s;
            nonce_end_r   <= nonce_end_s;
            digest_r      <= digest_s;
            wait_cnt_r    <= wait_cnt_s;
            msg_r         <= msg_s;
            begin_r       <= begin_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            found_r       <= found_s;
            exhausted_r   <= exhausted_s;
            timeout_r     <= timeout_s;
            found_nonce_r <= found_nonce_s;
            found_hash_r  <= found_hash_s;
            hash_count_r  <= hash_count_s;
        end
    end

    assign core.inputMsg         = msg_r;
    assign core.inputLength      = 64'(PREFIX_W + 32);
    assign core.beginComputation = begin_r;
    assign busy                  = busy_r;
    assign done                  = done_r;
    assign found                 = found_r;
    assign exhausted             = exhausted_r;
    assign timeout_err           = timeout_r;
    assign found_nonce           = found_nonce_r;
    assign found_hash            = found_hash_r;
    assign hash_count            = hash_count_r;

endmodule

// File: doc/sha_nonce_dispatcher.md
# sha_nonce_dispatcher

Initiator-side controller for `SHAcomputationalBlock`. For each candidate nonce it builds a single-block message from a fixed header prefix and the nonce, pulses `beginComputation`, waits for `computationComplete`, and compares the returned digest against a 256-bit target. The search stops when a digest is below target, the nonce range is exhausted, the core times out, or the host aborts. It sits between the miner's job registers and the SHA core.

## Interface
- `PREFIX_W`, default 408: prefix width in bits. `PREFIX_W + 32` must be ≤ 440.
- `TIMEOUT`, default 255: maximum number of WAIT cycles per hash before the search is declared failed.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a search. Sampled only in IDLE.
- `abort`  in  1  terminates the search from any non-IDLE state.
- `prefix`  in  PREFIX_W  header prefix. Captured at start.
- `target`  in  256  difficulty target. Captured at start.
- `nonce_start`  in  32  first nonce. Captured at start.
- `nonce_end`  in  32  last nonce, inclusive. Captured at start.
- `inputMsg`  out  440  to core. Value is `{prefix, nonce}`, right-aligned and zero-extended.
- `inputLength`  out  64  to core. Constant `PREFIX_W + 32`.
- `beginComputation`  out  1  to core. One-cycle pulse per nonce.
- `computationComplete`  in  1  from core. Level signal.
- `SHAoutput`  in  256  from core. Digest, valid while complete is high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a search.
- `found`, `exhausted`, `timeout_err`  out  1 each  result flags. Sticky until the next accepted start.
- `found_nonce`  out  32  nonce that produced the winning digest.
- `found_hash`  out  256  winning digest.
- `hash_count`  out  32  number of digests checked in this search.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE
  - `start` = 1: capture the inputs, set nonce = `nonce_start`, clear the flags and `hash_count`, go to ISSUE.
  - `start` is ignored in every other state.
- ISSUE
  - `beginComputation` = 1 for exactly this cycle. Go to WAIT and clear the wait counter.
- WAIT
  - `computationComplete` is blanked in the first WAIT cycle, so a stale level from the previous hash is never accepted.
  - From the second WAIT cycle on, the first cycle with complete high latches `SHAoutput` and goes to CHECK.
  - If the counter reaches `TIMEOUT` first: set `timeout_err`, go to DONE.
- CHECK
  - Increment `hash_count`.
  - Unsigned 256-bit compare: digest < target → set `found`, latch `found_nonce`/`found_hash`, go to DONE.
  - Otherwise, if nonce == `nonce_end` → set `exhausted`, go to DONE.
  - Otherwise nonce += 1 (mod 2^32), go to ISSUE.
- DONE
  - `done` = 1 for this cycle, then go to IDLE.
- Nonce range
  - Termination is by equality only. If `nonce_end` < `nonce_start`, the search wraps from 0xFFFFFFFF to 0.
  - `nonce_start` == `nonce_end` → exactly one hash.
- `abort`
  - In ISSUE, WAIT or CHECK: go to DONE on the next cycle with no result flag set.
  - In ISSUE, the begin pulse still completes.
  - The SHA core is not reset. The next begin restarts it.
- Priority: `rst` > `abort` > normal transitions. `found` takes priority over `exhausted` on the last nonce.
- Stability: `inputMsg` and `inputLength` are registered and stay stable from ISSUE through CHECK.

## Timing
- Reset: state IDLE and every output 0, except `inputLength`, which is constant.
- Reset mid-search: outputs read 0 in the cycle after the reset edge. No further begin pulse is issued.
- Start latency: `start` sampled at edge k → `beginComputation` high in cycle k+1.
- Per-nonce cost: 1 (ISSUE) + L (WAIT, where L = cycles until complete is accepted, L ≥ 2) + 1 (CHECK).
- Result timing: flags and `found_*` are valid in the DONE cycle, alongside `done`. They hold afterwards.
- Timeout: `timeout_err` is raised exactly `TIMEOUT` cycles after entering WAIT if complete is never accepted.
- `hash_count`: saturates at 0xFFFFFFFF.

## Test plan
- Single hit. Core model has 200-cycle latency. Target = all ones, nonce range 5..5.
  - Expect one begin pulse with `inputMsg` = `{prefix, 32'd5}` and `inputLength` = 440.
  - Expect `found` = 1, `found_nonce` = 5, `hash_count` = 1, and one `done` pulse.
- Exhaust. Target = 0, range 10..13.
  - Expect exactly 4 begin pulses for nonces 10, 11, 12, 13.
  - Expect `exhausted` = 1, `found` = 0, `hash_count` = 4.
- Wrap. Target = 0, range 0xFFFFFFFE..0x00000001.
  - Expect nonces FFFFFFFE, FFFFFFFF, 0, 1, then `exhausted` with `hash_count` = 4.
- Mid-range hit. Model returns a digest < target only for nonce = start + 2, range 100..200.
  - Expect `found_nonce` = 102, `found_hash` = the model's digest, `hash_count` = 3, and no fourth begin pulse.
- Stuck core. Model never asserts complete, `TIMEOUT` = 255.
  - Expect `timeout_err` = 1 and `done` exactly 255 cycles after WAIT entry.
  - A stale complete held high from a previous hash is not accepted in the first WAIT cycle.
- Abort and reset.
  - Abort during WAIT → `done` with all flags 0. A following start runs normally.
  - `rst` mid-search → every output 0 next cycle. `start` during busy is ignored.
